// File: rtl/wdata_chan_mngr.sv
// Write-data channel manager: arbitrates for the data channel and streams each queued
// 128-bit payload as WDC_BEATS beats. Optional macro WDC_PARITY_EN adds per-byte even parity on w_par.
module wdata_chan_mngr #(
   parameter int WDC_DW       = 32,
   parameter int WDC_BEATS    = 4,
   parameter int WDC_PEND_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                req_wd,
   input  logic                gnt_wd,
   output logic                w_valid,
   input  logic                w_ready,
   output logic [3:0]          w_id,
   output logic [WDC_DW-1:0]   w_data,
   output logic                w_last,
   input  logic                next_rq,
   input  logic [3:0]          next_id,
   input  logic [127:0]        next_data,
   output logic                ren_id_data,
   output logic                pend_ovf
`ifdef WDC_PARITY_EN
   ,
   output logic [WDC_DW/8-1:0] w_par
`endif
);

   // state | meaning
   // IDLE  | no payload in flight; leave when a payload is pending
   // AREQ  | requesting the data channel, waiting for gnt_wd
   // BOUT  | streaming beats of the head payload

   localparam int BW = $clog2(WDC_BEATS);
   localparam int PW = $clog2(WDC_PEND_MAX) + 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(WDC_BEATS - 1);
   localparam logic [PW-1:0] PEND_FULL = PW'(WDC_PEND_MAX);

   typedef enum logic [1:0] {IDLE, AREQ, BOUT} state_t;

   state_t            state;
   logic [BW-1:0]     beat_cnt;
   logic [PW-1:0]     pend_cnt;
   logic [WDC_DW-1:0] beat_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         beat_cnt <= '0;
         req_wd   <= 1'b0;
         w_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pend_cnt != '0) begin
                  state  <= AREQ;
                  req_wd <= 1'b1;
               end
            end
            AREQ: begin
               if (gnt_wd) begin
                  state   <= BOUT;
                  req_wd  <= 1'b0;
                  w_valid <= 1'b1;
               end
            end
            BOUT: begin
               if (w_ready) begin
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt <= '0;
                     state    <= IDLE;
                     w_valid  <= 1'b0;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               beat_cnt <= '0;
               req_wd   <= 1'b0;
               w_valid  <= 1'b0;
            end
         endcase
      end
   end

   // A push and a pop in the same cycle cancel; a push into a full count is lost and flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_cnt <= '0;
         pend_ovf <= 1'b0;
      end else if (next_rq && !ren_id_data) begin
         if (pend_cnt == PEND_FULL) pend_ovf <= 1'b1;
         else                       pend_cnt <= pend_cnt + 1'b1;
      end else if (!next_rq && ren_id_data) begin
         pend_cnt <= pend_cnt - 1'b1;
      end
   end

   always_comb begin
      beat_word = next_data[int'(beat_cnt)*WDC_DW +: WDC_DW];
   end

   // Data and id are forced to zero outside BOUT so every output is quiet in reset and idle.
   assign w_last      = w_valid & (beat_cnt == LAST_BEAT);
   assign ren_id_data = w_last & w_ready;
   assign w_id        = w_valid ? next_id : 4'h0;
   assign w_data      = w_valid ? beat_word : '0;

`ifdef WDC_PARITY_EN
   for (genvar i = 0; i < WDC_DW/8; i++) begin : g_par
      assign w_par[i] = ^w_data[i*8 +: 8];
   end
`endif

endmodule

// File: tb/tb_wdata_chan_mngr.sv
// Scoreboard bench for wdata_chan_mngr: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_wdata_chan_mngr;
   localparam int DW    = 32;
   localparam int BEATS = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           gnt_wd = 1'b0;
   logic           w_ready = 1'b1;
   logic           next_rq = 1'b0;
   logic [3:0]     next_id = 4'h0;
   logic [127:0]   next_data = '0;
   logic           req_wd, w_valid, w_last, ren_id_data, pend_ovf;
   logic [3:0]     w_id;
   logic [DW-1:0]  w_data;
`ifdef WDC_PARITY_EN
   logic [DW/8-1:0] w_par;
`endif

   always #5 clk = ~clk;

   wdata_chan_mngr #(.WDC_DW(DW), .WDC_BEATS(BEATS), .WDC_PEND_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_wd(req_wd), .gnt_wd(gnt_wd),
      .w_valid(w_valid), .w_ready(w_ready), .w_id(w_id), .w_data(w_data), .w_last(w_last),
      .next_rq(next_rq), .next_id(next_id), .next_data(next_data),
      .ren_id_data(ren_id_data), .pend_ovf(pend_ovf)
`ifdef WDC_PARITY_EN
      , .w_par(w_par)
`endif
   );

   typedef struct packed {logic [3:0] id; logic [DW-1:0] data; logic last;} beat_t;
   typedef struct packed {logic [3:0] id; logic [127:0] data;} pay_t;

   beat_t exp_q[$];
   pay_t  up_q[$];
   beat_t e;
   int    n_vec = 0, n_err = 0;
   int    beat_idx = 0, ren_cnt = 0, gnt_lat = 1, req_cycles = 0, stall_left = 0;
   bit    gnt_force = 0, pop_flag = 0, prev_stall = 0;
   logic [DW-1:0] prev_data = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task update_head();
      if (up_q.size() > 0) begin
         next_id   = up_q[0].id;
         next_data = up_q[0].data;
      end else begin
         next_id   = 4'h0;
         next_data = '0;
      end
   endtask

   task automatic issue(input logic [3:0] id, input logic [127:0] data, input bit accept);
      pay_t  p;
      beat_t t;
      @(posedge clk); #1;
      next_rq = 1'b1;
      if (accept) begin
         p.id = id; p.data = data;
         up_q.push_back(p);
         for (int b = 0; b < BEATS; b++) begin
            t.id = id; t.data = data[b*DW +: DW]; t.last = (b == BEATS-1);
            exp_q.push_back(t);
         end
         update_head();
      end
   endtask

   task automatic idle_rq();
      @(posedge clk); #1;
      next_rq = 1'b0;
   endtask

   task automatic wait_drain(input int maxc);
      int c = 0;
      while ((exp_q.size() != 0 || w_valid || req_wd) && c < maxc) begin
         @(posedge clk); #2;
         c++;
      end
      chk_int("drain_in_time", int'(c < maxc), 1);
      repeat (3) @(posedge clk);
      #2;
   endtask

   // Upstream queue pops one cycle edge after the DUT asserted ren_id_data.
   always @(posedge clk) begin
      #1;
      if (pop_flag) begin
         pop_flag = 0;
         if (up_q.size() > 0) void'(up_q.pop_front());
         update_head();
      end
   end

   always @(posedge clk) begin
      #1;
      if (gnt_force) gnt_wd = 1'b1;
      else if (req_wd) begin
         gnt_wd = (req_cycles >= gnt_lat);
         req_cycles++;
      end else begin
         gnt_wd = 1'b0;
         req_cycles = 0;
      end
   end

   always @(posedge clk) begin
      #1;
      if (stall_left > 0 && w_valid && beat_idx == 2) begin
         w_ready = 1'b0;
         stall_left--;
      end else w_ready = 1'b1;
   end

   always @(negedge clk) begin
      if (!rst_n) prev_stall = 0;
      else begin
         if (w_valid && w_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL beat_unexpected: got id %0h data %0h expected no beat", w_id, w_data);
            end else begin
               e = exp_q.pop_front();
               chk("beat_id", w_id, e.id);
               chk("beat_data", w_data, e.data);
               chk("beat_last", w_last, e.last);
               chk("beat_ren", ren_id_data, e.last);
`ifdef WDC_PARITY_EN
               for (int k = 0; k < DW/8; k++) chk("beat_par", w_par[k], ^e.data[k*8 +: 8]);
`endif
               if (e.last) beat_idx = 0; else beat_idx++;
            end
            if (ren_id_data) begin
               pop_flag = 1;
               ren_cnt++;
            end
         end else chk("ren_quiet", ren_id_data, 1'b0);
         if (prev_stall) begin
            chk("hold_valid", w_valid, 1'b1);
            chk("hold_data", w_data, prev_data);
         end
         prev_stall = w_valid && !w_ready;
         prev_data  = w_data;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int c;
      int ren_before;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_req", req_wd, 1'b0);
      chk("rst_valid", w_valid, 1'b0);
      chk("rst_last", w_last, 1'b0);
      chk("rst_ren", ren_id_data, 1'b0);
      chk("rst_ovf", pend_ovf, 1'b0);
      chk("rst_data", w_data, '0);
      rst_n = 1'b1;

      // Grant with nothing pending must not start a burst.
      @(posedge clk); #1;
      gnt_force = 1;
      repeat (3) @(posedge clk);
      #2;
      chk("gnt_ignored_valid", w_valid, 1'b0);
      chk("gnt_ignored_req", req_wd, 1'b0);
      gnt_force = 0;
      repeat (2) @(posedge clk);

      // Single payload and request latency.
      issue(4'h2, 128'h44444444_33333333_22222222_11111111, 1);
      idle_rq();
      chk("req_lat_1", req_wd, 1'b0);
      @(posedge clk); #1;
      chk("req_lat_2", req_wd, 1'b1);
      wait_drain(50);
      chk_int("ren_single", ren_cnt, 1);

      // Backpressure on beat 2 for three cycles.
      stall_left = 3;
      issue(4'h5, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1);
      idle_rq();
      wait_drain(60);
      chk_int("stall_applied", stall_left, 0);
      chk_int("ren_stall", ren_cnt, 2);

      // Grant held off for ten cycles.
      gnt_lat = 10;
      issue(4'h7, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1);
      idle_rq();
      c = 0;
      while (!req_wd && c < 5) begin
         @(posedge clk); #2;
         c++;
      end
      chk_int("req_seen", int'(req_wd), 1);
      for (int i = 0; i < 11; i++) begin
         chk("gdly_req", req_wd, 1'b1);
         chk("gdly_valid", w_valid, 1'b0);
         @(posedge clk); #2;
      end
      chk("gdly_valid_after", w_valid, 1'b1);
      chk("gdly_req_after", req_wd, 1'b0);
      gnt_lat = 1;
      wait_drain(60);
      chk_int("ren_gdly", ren_cnt, 3);

      // Back-to-back payloads, then push coincident with pop at full count, then overflow.
      for (int i = 0; i < 4; i++)
         issue(4'(i), {4{8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i)}}, 1);
      idle_rq();
      c = 0;
      do begin
         @(posedge clk); #2;
         c++;
      end while (!(w_valid && w_last && w_ready) && c < 40);
      chk_int("last0_seen", int'(c < 40), 1);
      begin
         pay_t  p;
         beat_t t;
         next_rq = 1'b1;
         p.id = 4'h4; p.data = 128'h99999999_88888888_77777777_66666666;
         up_q.push_back(p);
         for (int b = 0; b < BEATS; b++) begin
            t.id = 4'h4; t.data = p.data[b*DW +: DW]; t.last = (b == BEATS-1);
            exp_q.push_back(t);
         end
      end
      @(posedge clk); #1;
      next_rq = 1'b0;
      chk("ovf_after_coincident", pend_ovf, 1'b0);
      issue(4'h9, 128'h1, 0);
      idle_rq();
      chk("ovf_set", pend_ovf, 1'b1);
      wait_drain(200);
      chk_int("ren_b2b", ren_cnt, 8);
      chk("ovf_sticky", pend_ovf, 1'b1);
      chk("no_extra_req", req_wd, 1'b0);

      // Reset in the middle of beat 1.
      issue(4'hA, 128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D, 1);
      idle_rq();
      c = 0;
      do begin
         @(posedge clk); #2;
         c++;
      end while (!(w_valid && beat_idx == 1) && c < 30);
      chk_int("beat1_seen", int'(c < 30), 1);
      ren_before = ren_cnt;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", req_wd, 1'b0);
      chk("mid_rst_valid", w_valid, 1'b0);
      chk("mid_rst_last", w_last, 1'b0);
      chk("mid_rst_ren", ren_id_data, 1'b0);
      chk("mid_rst_ovf", pend_ovf, 1'b0);
      chk("mid_rst_data", w_data, '0);
      chk("mid_rst_id", w_id, 4'h0);
      exp_q.delete();
      up_q.delete();
      update_head();
      beat_idx = 0;
      pop_flag = 0;
      repeat (2) @(posedge clk);
      #2;
      chk_int("mid_rst_no_pop", ren_cnt, ren_before);
      chk("mid_rst_held", w_valid, 1'b0);
      rst_n = 1'b1;
      issue(4'hB, 128'h5A5A5A5A_A5A5A5A5_12345678_9ABCDEF0, 1);
      idle_rq();
      wait_drain(60);
      chk_int("ren_after_rst", ren_cnt, ren_before + 1);

`ifdef WDC_PARITY_EN
      issue(4'h1, {96'h0, 32'h010307FF}, 1);
      idle_rq();
      c = 0;
      while (!w_valid && c < 10) begin
         @(posedge clk); #2;
         c++;
      end
      chk("par_vec", w_par, 4'b1010);
      wait_drain(60);
`endif

      chk_int("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
